// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the data-ram arbiter.
// - FUNCT3_LS_* : load/store size codes (RISC-V funct3 encoding)
// - state_t     : arbiter FSM state encoding
package ram_arbiter_pkg;

  localparam logic [2:0] FUNCT3_LS_B  = 3'b000;
  localparam logic [2:0] FUNCT3_LS_H  = 3'b001;
  localparam logic [2:0] FUNCT3_LS_W  = 3'b010;
  localparam logic [2:0] FUNCT3_LS_BU = 3'b100;
  localparam logic [2:0] FUNCT3_LS_HU = 3'b101;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/ram_load_align.sv
// Combinational load alignment and access-shape checker.
// Extracts the addressed byte/half/word from a full ram word and extends it
// per the size code; also flags misaligned addresses and unknown size codes.
// Ports:
//   word       in  32  full word read from the ram
//   addr       in  2   byte offset within the word
//   size       in  3   FUNCT3_LS_* code
//   rdata      out 32  extracted, extended load data (0 for bad sizes)
//   misaligned out 1   H/HU on an odd address, W on a non-word address
//   bad_size   out 1   size code is not one of B/H/W/BU/HU
module ram_load_align
  import ram_arbiter_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  size,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bad_size
);

  logic [31:0]        byte_sh;
  logic [31:0]        half_sh;
  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  assign byte_sh = word >> {addr, 3'b000};
  assign half_sh = word >> {addr[1], 4'b0000};
  assign lane_b  = signed'(byte_sh[7:0]);
  assign lane_h  = signed'(half_sh[15:0]);

  always_comb begin
    rdata      = '0;
    misaligned = 1'b0;
    bad_size   = 1'b0;
    case (size)
      FUNCT3_LS_B:  rdata = 32'(lane_b);
      FUNCT3_LS_BU: rdata = {24'd0, byte_sh[7:0]};
      FUNCT3_LS_H: begin
        rdata      = 32'(lane_h);
        misaligned = addr[0];
      end
      FUNCT3_LS_HU: begin
        rdata      = {16'd0, half_sh[15:0]};
        misaligned = addr[0];
      end
      FUNCT3_LS_W: begin
        rdata      = word;
        misaligned = |addr;
      end
      default:      bad_size = 1'b1;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data ram.
// Port 0 is the CPU load/store unit, port 1 the debug/program loader.
// One access is in flight at a time; each accepted request gets a single
// response pulse one cycle after acceptance.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req_valid/req_ready[1:0] per-port request handshake (ready only in IDLE)
//   req_we[1:0]              per-port write enable
//   req_addr0/1, req_size0/1, req_wd0/1   per-port request fields
//   rsp_valid[1:0]           one-cycle response pulse to the owning port
//   rsp_rdata, rsp_err       response data / error flag
//   mem_we/addr/size/wd      to the ram (which samples on the falling edge)
//   mem_rd                   word read from the ram
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_we,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [2:0]  req_size0,
  input  logic [2:0]  req_size1,
  input  logic [31:0] req_wd0,
  input  logic [31:0] req_wd1,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [29:0] SIZE_WORDS = 30'(SIZE);

  state_t      state, state_next;
  logic        rr_last;
  logic        lat_port, lat_we, lat_err;
  logic [31:0] lat_addr, lat_wd;
  logic [2:0]  lat_size;

  logic        gnt_port, accept;
  logic        sel_we;
  logic [31:0] sel_addr, sel_wd;
  logic [2:0]  sel_size;
  logic [1:0]  chk_addr;
  logic [2:0]  chk_size;
  logic [31:0] al_rdata;
  logic        al_mis, al_bad, out_of_range, acc_err;

  // Grant: a lone requester wins; when both are valid the port that was
  // not served last wins.
  always_comb begin
    gnt_port  = req_valid[1];
    if (&req_valid) gnt_port = ~rr_last;
    req_ready = '0;
    if (state == ST_IDLE && |req_valid) req_ready = gnt_port ? 2'b10 : 2'b01;
  end

  assign accept   = |(req_valid & req_ready);
  assign sel_we   = gnt_port ? req_we[1]  : req_we[0];
  assign sel_addr = gnt_port ? req_addr1  : req_addr0;
  assign sel_size = gnt_port ? req_size1  : req_size0;
  assign sel_wd   = gnt_port ? req_wd1    : req_wd0;

  // One aligner serves both jobs: shape checking of the candidate request in
  // IDLE, and extraction of the returned word in ACCESS.
  assign chk_addr = (state == ST_ACCESS) ? lat_addr[1:0] : sel_addr[1:0];
  assign chk_size = (state == ST_ACCESS) ? lat_size      : sel_size;

  ram_load_align u_align (
    .word       (mem_rd),
    .addr       (chk_addr),
    .size       (chk_size),
    .rdata      (al_rdata),
    .misaligned (al_mis),
    .bad_size   (al_bad)
  );

  assign out_of_range = sel_addr[31:2] >= SIZE_WORDS;
  assign acc_err      = al_mis | al_bad | out_of_range;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Accept edge: latch control of the granted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last   <= 1'b1;
      lat_port  <= 1'b0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (accept) begin
        rr_last  <= gnt_port;
        lat_port <= gnt_port;
        lat_we   <= sel_we;
        lat_err  <= acc_err;
      end
      // Response edge: the ram has settled since the falling edge
      if (state == ST_ACCESS) begin
        rsp_valid[lat_port] <= 1'b1;
        rsp_rdata           <= (lat_we | lat_err) ? '0 : al_rdata;
        rsp_err             <= lat_err;
      end
    end
  end

  // Accept edge: latch data fields (no reset, they only feed the ram)
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_addr <= sel_addr;
      lat_size <= sel_size;
      lat_wd   <= sel_wd;
    end
  end

  // Ram drive: fields come straight from the latches, so they hold their
  // last values outside ACCESS; only the write strobe is state-gated.
  assign mem_we   = (state == ST_ACCESS) & lat_we & ~lat_err & ~rst;
  assign mem_addr = lat_addr;
  assign mem_wd   = lat_wd;
  assign mem_size = lat_we ? lat_size : FUNCT3_LS_W;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural falling-edge ram.
module tb_ram_arbiter;

  localparam int SIZE = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_we = '0;
  logic [31:0] req_addr0 = '0, req_addr1 = '0;
  logic [2:0]  req_size0 = '0, req_size1 = '0;
  logic [31:0] req_wd0 = '0, req_wd1 = '0;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [2:0]  mem_size;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_size0(req_size0), .req_size1(req_size1),
    .req_wd0(req_wd0), .req_wd1(req_wd1),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Behavioural ram: writes on the falling edge, asynchronous word read.
  logic [31:0] ram_q [SIZE];
  assign mem_rd = ram_q[mem_addr[11:2]];

  always @(negedge clk) begin
    if (mem_we && mem_addr[31:12] == 20'd0) begin
      case (mem_size[1:0])
        2'b00:   ram_q[mem_addr[11:2]][8*mem_addr[1:0] +: 8] = mem_wd[7:0];
        2'b01:   ram_q[mem_addr[11:2]][16*mem_addr[1] +: 16] = mem_wd[15:0];
        default: ram_q[mem_addr[11:2]] = mem_wd;
      endcase
    end
  end

  // Reference model: flat byte-addressed memory, little-endian.
  logic [7:0] byte_mem [SIZE*4];

  task automatic ref_access(input bit we, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wd, output logic [31:0] rd, output bit err);
    int unsigned nbytes;
    logic [31:0] v;
    nbytes = 1 << size[1:0];
    v = '0;
    err = (size == 3'd3 || size == 3'd6 || size == 3'd7) ||
          ((addr & (nbytes - 1)) != 0) || ((addr >> 2) >= SIZE);
    rd = '0;
    if (!err) begin
      for (int i = 0; i < int'(nbytes); i++) begin
        if (we) byte_mem[addr + i] = wd[8*i +: 8];
        else    v = v | (32'(byte_mem[addr + i]) << (8*i));
      end
      if (size == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
      if (size == 3'b001 && v[15]) v = v | 32'hFFFF0000;
      if (!we) rd = v;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
  endtask

  task automatic drive_port(input int port, input bit we, input logic [31:0] addr,
                            input logic [2:0] size, input logic [31:0] wd);
    req_we[port] = we;
    if (port == 0) begin req_addr0 = addr; req_size0 = size; req_wd0 = wd; end
    else           begin req_addr1 = addr; req_size1 = size; req_wd1 = wd; end
  endtask

  // Single transaction on one port; checks latency, strobe, response, pulse width.
  task automatic do_req(input string nm, input int port, input bit we, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_err);
    int waitc;
    @(negedge clk);
    drive_port(port, we, addr, size, wd);
    req_valid[port] = 1'b1;
    #1;
    waitc = 0;
    while (!req_ready[port] && waitc < 20) begin
      @(negedge clk); #1;
      waitc++;
    end
    if (!req_ready[port]) begin
      n_total++;
      $display("FAIL %s ready_timeout: got ready=%b, want grant within 20 cycles", nm, req_ready);
      req_valid[port] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[port] = 1'b0;
    check({nm, " rsp_early"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check({nm, " mem_we"}, 32'(mem_we), 32'(we && !exp_err));
    @(posedge clk); #1;
    check({nm, " rsp_valid"}, 32'(rsp_valid), 32'd1 << port);
    check({nm, " rdata"}, rsp_rdata, exp_rd);
    check({nm, " err"}, 32'(rsp_err), 32'(exp_err));
    @(posedge clk); #1;
    check({nm, " pulse_end"}, 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [31:0] mrd, exp_w [2];
    bit          merr;
    int          left [2];
    int          order [$];
    int          pend [$];
    int          nrsp, p;
    logic [1:0]  g;

    foreach (ram_q[i]) ram_q[i] = '0;
    foreach (byte_mem[i]) byte_mem[i] = '0;

    tbl[0]  = '{0, 1, 32'h10,   3'b010, 32'hDEADBEEF, 32'h0,        0};
    tbl[1]  = '{0, 0, 32'h10,   3'b010, 32'h0,        32'hDEADBEEF, 0};
    tbl[2]  = '{1, 1, 32'h20,   3'b010, 32'h80F17F02, 32'h0,        0};
    tbl[3]  = '{0, 0, 32'h23,   3'b000, 32'h0,        32'hFFFFFF80, 0};
    tbl[4]  = '{0, 0, 32'h23,   3'b100, 32'h0,        32'h00000080, 0};
    tbl[5]  = '{1, 0, 32'h22,   3'b001, 32'h0,        32'hFFFF80F1, 0};
    tbl[6]  = '{0, 0, 32'h20,   3'b101, 32'h0,        32'h00007F02, 0};
    tbl[7]  = '{0, 1, 32'h21,   3'b000, 32'h000000AA, 32'h0,        0};
    tbl[8]  = '{1, 0, 32'h20,   3'b010, 32'h0,        32'h80F1AA02, 0};
    tbl[9]  = '{0, 0, 32'h12,   3'b010, 32'h0,        32'h0,        1};
    tbl[10] = '{0, 0, 32'h1000, 3'b010, 32'h0,        32'h0,        1};
    tbl[11] = '{0, 1, 32'h1000, 3'b010, 32'h55555555, 32'h0,        1};
    tbl[12] = '{0, 0, 32'h10,   3'b010, 32'h0,        32'hDEADBEEF, 0};
    tbl[13] = '{0, 1, 32'h30,   3'b010, 32'hCAFEF00D, 32'h0,        0};
    tbl[14] = '{0, 0, 32'h21,   3'b001, 32'h0,        32'h0,        1};
    tbl[15] = '{1, 0, 32'h10,   3'b011, 32'h0,        32'h0,        1};

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 16; i++) begin
      ref_access(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].wd, mrd, merr);
      do_req($sformatf("vec%0d", i), int'(tbl[i].port), tbl[i].we, tbl[i].addr,
             tbl[i].size, tbl[i].wd, tbl[i].exp_rd, tbl[i].exp_err);
    end

    // Reset during the ACCESS cycle of a store: dropped, no write, no response
    @(negedge clk);
    drive_port(0, 1'b1, 32'h30, 3'b010, 32'h12345678);
    req_valid = 2'b01;
    #1;
    check("rstacc ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    check("rstacc mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    check("rstacc rsp_a", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rstacc rsp_b", 32'(rsp_valid), 32'd0);

    // Contention: both ports valid for 4 reads each; first grant after reset is port 0
    ref_access(1'b0, 32'h10, 3'b010, 32'h0, exp_w[0], merr);
    ref_access(1'b0, 32'h20, 3'b010, 32'h0, exp_w[1], merr);
    @(negedge clk);
    drive_port(0, 1'b0, 32'h10, 3'b010, 32'h0);
    drive_port(1, 1'b0, 32'h20, 3'b010, 32'h0);
    req_valid = 2'b11;
    left[0] = 4; left[1] = 4; nrsp = 0;
    #1;
    for (int c = 0; c < 40 && nrsp < 8; c++) begin
      g = req_ready;
      @(posedge clk); #1;
      if (rsp_valid != 2'b00) begin
        if (pend.size() == 0) begin
          check("rr rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          p = pend.pop_front();
          check($sformatf("rr rsp%0d port", nrsp), 32'(rsp_valid), 32'd1 << p);
          check($sformatf("rr rsp%0d rdata", nrsp), rsp_rdata, exp_w[p]);
        end
        nrsp++;
      end
      for (int q = 0; q < 2; q++) begin
        if (g[q] && req_valid[q]) begin
          order.push_back(q);
          pend.push_back(q);
          left[q]--;
          if (left[q] == 0) req_valid[q] = 1'b0;
        end
      end
      @(negedge clk); #1;
    end
    req_valid = 2'b00;
    check("rr responses", 32'(nrsp), 32'd8);
    check("rr grants", 32'(order.size()), 32'd8);
    for (int k = 0; k < order.size(); k++)
      check($sformatf("rr grant%0d", k), 32'(order[k]), 32'(k % 2));

    // The dropped store left the prior value in place
    do_req("after_rst LW 0x30", 0, 1'b0, 32'h30, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0);

    // Randomized traffic against the byte-level model
    for (int t = 0; t < 60; t++) begin
      int          port;
      bit          we;
      logic [2:0]  size;
      logic [31:0] addr, wd;
      port = int'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      if (we) begin
        case ($urandom_range(0, 6))
          0: size = 3'd0;  1: size = 3'd1;  2, 3: size = 3'd2;
          4: size = 3'd3;  5: size = 3'd6;  default: size = 3'd7;
        endcase
      end else begin
        size = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 15) == 0) addr = 32'h1000 + 32'($urandom_range(0, 255));
      else                            addr = 32'($urandom_range(0, 127));
      wd = $urandom;
      ref_access(we, addr, size, wd, mrd, merr);
      do_req($sformatf("rnd%0d", t), port, we, addr, size, wd, mrd, merr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
